alarm_ringer: RTL and testbench
===============================

// Module: alarm_ringer
// PURPOSE
//   Consumer side of the alarm-setting interface.
//   - Compares the stored alarm time (BCD ahour/amin) with the running clock time.
//   - On a match, drives a gated square-wave buzzer.
//   - Supports stop, a bounded number of snoozes, and a ring timeout.
//   - Sits between the alarm setter, the timekeeping counters and the board buzzer/LEDs.
// PARAMETERS
//   RING_SECS    60    seconds the buzzer rings before auto-stop (1..255)
//   SNOOZE_SECS  300   seconds of silence after snooze before re-ring (1..65535)
//   MAX_SNOOZE   3     snoozes allowed per alarm event (0..15)
//   TONE_HALF    4     clk cycles per buzzer half-period while tone is on (>=1)
// PORTS
//   clk        in   1  system clock; all logic on posedge
//   rst        in   1  synchronous reset, active-high
//   sec_tick   in   1  one-clk pulse per second from the timebase
//   hour       in   8  current hour, BCD 00..23
//   min        in   8  current minute, BCD 00..59
//   sec        in   8  current second, BCD 00..59
//   ahour      in   8  alarm hour, BCD
//   amin       in   8  alarm minute, BCD
//   alarm_en   in   1  level; 0 forces IDLE and silences
//   stop       in   1  level, debounced; dismisses the alarm
//   snooze     in   1  level, debounced; rising edge detected internally
//   buzzer     out  1  square-wave buzzer drive
//   ringing    out  1  1 in RINGING
//   snoozing   out  1  1 in SNOOZE
//   snooze_cnt out  4  snoozes used in the current event
// BEHAVIOUR
//   Reset: state=IDLE. buzzer, ringing, snoozing, snooze_cnt, all counters and the tone divider = 0.
//   Alarm armed: alarm_en=1 and {ahour,amin} != 16'h0000. A 00:00 alarm means "not set".
//   match = armed && hour==ahour && min==amin && sec==8'h00 (combinational compare).
//   States:
//     IDLE -> RINGING on match. Loads ring_ctr=RING_SECS and clears snooze_cnt.
//     RINGING -> DONE on stop=1.
//     RINGING -> SNOOZE on snooze rising edge when snooze_cnt<MAX_SNOOZE.
//       Loads snz_ctr=SNOOZE_SECS and increments snooze_cnt.
//       A snooze edge with snooze_cnt==MAX_SNOOZE is ignored.
//     RINGING: ring_ctr decrements on sec_tick; at 1 with sec_tick -> DONE.
//     SNOOZE -> DONE on stop=1.
//     SNOOZE: snz_ctr decrements on sec_tick; at 1 with sec_tick -> RINGING, reloads ring_ctr.
//     DONE -> IDLE once (hour,min) != (ahour,amin). Blocks re-trigger within the same minute.
//   Priority in one cycle: alarm_en=0 > stop > snooze edge > counter expiry.
//     A snooze edge coinciding with sec_tick loads SNOOZE_SECS; no decrement that cycle.
//   alarm_en=0 in any state -> IDLE next clk. Outputs clear and snooze_cnt clears.
//   Latency: state and outputs are registered, so the effect shows 1 clk after the causing input edge.
//   Tone:
//     Gate is on during even-numbered seconds of RINGING; 1 s on / 1 s off, starting with on.
//     A gate bit toggles on each sec_tick while in RINGING and resets to 1 on entry to RINGING.
//     While gate=1, buzzer toggles every TONE_HALF clks from a free divider that resets on RINGING entry.
//     Outside RINGING, or with gate=0, buzzer=0.
//   Alarm changed mid-ring: current event continues. The new value only affects the next IDLE match.
//   Mid-operation rst: behaves exactly as at power-up, same cycle-next values.
//   Counter widths: ring_ctr 8 b; snz_ctr 16 b; never underflow (expiry checked at value 1).
// TESTING
//   Set ahour=07, amin=30; drive time 07:29:59 -> 07:30:00.
//     -> ringing=1 one clk later; buzzer toggles every 4 clk.
//   Ahour=amin=00 and time 00:00:00 -> stays IDLE, buzzer=0.
//   Ringing, assert stop -> DONE.
//     -> No re-ring while time remains 07:30.
//     -> Re-arms (IDLE) at 07:31.
//   Ringing, 4 snooze edges across 3 SNOOZE periods (SNOOZE_SECS=5 in sim).
//     -> snooze_cnt=1,2,3; the 4th edge is ignored; ringing stays 1.
//   Ringing, no input, RING_SECS=3 -> DONE after exactly 3 sec_ticks.
//     -> Buzzer active only in seconds 1 and 3.
//   Snooze edge on the same clk as sec_tick -> snz_ctr=SNOOZE_SECS.
//     -> alarm_en=0 mid-SNOOZE forces IDLE with snooze_cnt=0.
//     -> rst mid-RINGING forces all outputs to 0.

Source files
------------

// File: rtl/alarm_ringer.sv
// Alarm consumer: compares the stored BCD alarm time with the running clock and rings a gated
// square-wave buzzer, with stop, a limited number of snoozes and a ring timeout.
module alarm_ringer #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3,
  parameter int TONE_HALF   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic [7:0] hour,
  input  logic [7:0] min,
  input  logic [7:0] sec,
  input  logic [7:0] ahour,
  input  logic [7:0] amin,
  input  logic       alarm_en,
  input  logic       stop,
  input  logic       snooze,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [3:0] snooze_cnt
);

  // state   | meaning
  // IDLE    | armed and waiting for the alarm minute to start
  // RINGING | buzzer gated on/off each second, ring timeout running
  // SNOOZE  | silent, snooze timer running towards a re-ring
  // DONE    | dismissed; waits for the alarm minute to pass
  typedef enum logic [1:0] {
    S_IDLE,
    S_RINGING,
    S_SNOOZE,
    S_DONE
  } state_t;

  localparam int DIV_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TONE_HALF - 1);
  localparam logic [7:0]       RING_LD  = 8'(RING_SECS);
  localparam logic [15:0]      SNZ_LD   = 16'(SNOOZE_SECS);
  localparam logic [3:0]       MAX_SNZ  = 4'(MAX_SNOOZE);

  state_t           state;
  logic [7:0]       ring_ctr;
  logic [15:0]      snz_ctr;
  logic [DIV_W-1:0] div;
  logic             gate;
  logic             tone;
  logic             snooze_q;

  logic armed;
  logic same_minute;
  logic match;
  logic snz_edge;
  logic snz_ok;
  logic gate_n;
  logic tone_n;

  always_comb begin
    armed       = alarm_en && ({ahour, amin} != 16'h0000);
    same_minute = (hour == ahour) && (min == amin);
    match       = armed && same_minute && (sec == 8'h00);
    snz_edge    = snooze && !snooze_q;
    snz_ok      = snz_edge && (snooze_cnt < MAX_SNZ);
    gate_n      = gate ^ sec_tick;
    tone_n      = tone ^ (div == DIV_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ring_ctr   <= '0;
      snz_ctr    <= '0;
      div        <= '0;
      gate       <= 1'b0;
      tone       <= 1'b0;
      snooze_q   <= 1'b0;
      buzzer     <= 1'b0;
      ringing    <= 1'b0;
      snoozing   <= 1'b0;
      snooze_cnt <= '0;
    end else begin
      snooze_q <= snooze;
      if (!alarm_en) begin
        state      <= S_IDLE;
        ring_ctr   <= '0;
        snz_ctr    <= '0;
        div        <= '0;
        gate       <= 1'b0;
        tone       <= 1'b0;
        buzzer     <= 1'b0;
        ringing    <= 1'b0;
        snoozing   <= 1'b0;
        snooze_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (match) begin
              state      <= S_RINGING;
              ring_ctr   <= RING_LD;
              snooze_cnt <= '0;
              ringing    <= 1'b1;
              gate       <= 1'b1;
              tone       <= 1'b0;
              div        <= '0;
              buzzer     <= 1'b0;
            end
          end

          S_RINGING: begin
            if (stop || (!snz_ok && sec_tick && ring_ctr == 8'd1)) begin
              state   <= S_DONE;
              ringing <= 1'b0;
              buzzer  <= 1'b0;
              gate    <= 1'b0;
              tone    <= 1'b0;
              div     <= '0;
            end else if (snz_ok) begin
              // A coinciding sec_tick is deliberately not counted against the fresh snooze period.
              state      <= S_SNOOZE;
              snz_ctr    <= SNZ_LD;
              snooze_cnt <= snooze_cnt + 4'd1;
              ringing    <= 1'b0;
              snoozing   <= 1'b1;
              buzzer     <= 1'b0;
              gate       <= 1'b0;
              tone       <= 1'b0;
              div        <= '0;
            end else begin
              if (sec_tick) ring_ctr <= ring_ctr - 8'd1;
              div    <= (div == DIV_LAST) ? '0 : div + 1'b1;
              gate   <= gate_n;
              tone   <= tone_n;
              buzzer <= gate_n & tone_n;
            end
          end

          S_SNOOZE: begin
            if (stop) begin
              state    <= S_DONE;
              snoozing <= 1'b0;
            end else if (sec_tick) begin
              if (snz_ctr == 16'd1) begin
                state    <= S_RINGING;
                ring_ctr <= RING_LD;
                snoozing <= 1'b0;
                ringing  <= 1'b1;
                gate     <= 1'b1;
                tone     <= 1'b0;
                div      <= '0;
                buzzer   <= 1'b0;
              end else begin
                snz_ctr <= snz_ctr - 16'd1;
              end
            end
          end

          S_DONE: begin
            if (!same_minute) state <= S_IDLE;
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alarm_ringer.sv
// Bench for alarm_ringer: vector table, directed multi-cycle sequences and a randomized run
// compared every cycle against an event-level reference model.
module tb_alarm_ringer;
  localparam int RING = 3;
  localparam int SNZ  = 5;
  localparam int MAXS = 3;
  localparam int TH   = 4;

  logic       clk = 1'b0;
  logic       rst, sec_tick, alarm_en, stop, snooze;
  logic [7:0] hour, min, sec, ahour, amin;
  logic       buzzer, ringing, snoozing;
  logic [3:0] snooze_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alarm_ringer #(
    .RING_SECS(RING), .SNOOZE_SECS(SNZ), .MAX_SNOOZE(MAXS), .TONE_HALF(TH)
  ) dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick), .hour(hour), .min(min), .sec(sec),
    .ahour(ahour), .amin(amin), .alarm_en(alarm_en), .stop(stop), .snooze(snooze),
    .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing), .snooze_cnt(snooze_cnt)
  );

  // Reference model: event state plus elapsed cycles/seconds since the ring started.
  typedef enum {M_IDLE, M_RING, M_SNZ, M_DONE} mstate_t;
  mstate_t m_state = M_IDLE;
  int m_ring_left = 0, m_snz_left = 0, m_cnt = 0, m_k = 0, m_ticks = 0;
  logic m_prev = 1'b0;

  task automatic model_step();
    bit edge_s, same;
    edge_s = snooze && !m_prev;
    m_prev = rst ? 1'b0 : snooze;
    same   = (hour == ahour) && (min == amin);
    if (rst) begin
      m_state = M_IDLE; m_cnt = 0; m_k = 0; m_ticks = 0; m_ring_left = 0; m_snz_left = 0;
    end else if (!alarm_en) begin
      m_state = M_IDLE; m_cnt = 0;
    end else begin
      case (m_state)
        M_IDLE: if (same && sec == 8'h00 && {ahour, amin} != 16'h0000) begin
          m_state = M_RING; m_ring_left = RING; m_cnt = 0; m_k = 0; m_ticks = 0;
        end
        M_RING: begin
          if (stop) m_state = M_DONE;
          else if (edge_s && m_cnt < MAXS) begin
            m_state = M_SNZ; m_snz_left = SNZ; m_cnt++;
          end else if (sec_tick && m_ring_left == 1) m_state = M_DONE;
          else begin
            m_k++;
            if (sec_tick) begin m_ticks++; m_ring_left--; end
          end
        end
        M_SNZ: begin
          if (stop) m_state = M_DONE;
          else if (sec_tick) begin
            if (m_snz_left == 1) begin
              m_state = M_RING; m_ring_left = RING; m_k = 0; m_ticks = 0;
            end else m_snz_left--;
          end
        end
        M_DONE: if (!same) m_state = M_IDLE;
        default: m_state = M_IDLE;
      endcase
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cyc();
    int e_buz;
    @(posedge clk);
    model_step();
    #1;
    e_buz = (m_state == M_RING && (m_ticks % 2) == 0 && ((m_k / TH) % 2) == 1) ? 1 : 0;
    chk("model_ringing",  int'(ringing),    (m_state == M_RING) ? 1 : 0);
    chk("model_snoozing", int'(snoozing),   (m_state == M_SNZ) ? 1 : 0);
    chk("model_buzzer",   int'(buzzer),     e_buz);
    chk("model_cnt",      int'(snooze_cnt), m_cnt);
  endtask

  task automatic do_reset();
    rst = 1'b1; sec_tick = 1'b0; stop = 1'b0; snooze = 1'b0; alarm_en = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic trigger();
    alarm_en = 1'b1; ahour = 8'h07; amin = 8'h30; stop = 1'b0; snooze = 1'b0; sec_tick = 1'b0;
    hour = 8'h07; min = 8'h29; sec = 8'h59;
    cyc();
    min = 8'h30; sec = 8'h00;
    cyc();
    chk("trig_ring", int'(ringing), 1);
    sec = 8'h01;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      sec_tick = 1'b1; cyc(); sec_tick = 1'b0; cyc(); cyc();
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  typedef struct {
    logic r, en, stp, sz, tk;
    logic [7:0] hr, mn, sc, ah, am;
    int er, es, eb, ec;
  } vec_t;

  function automatic vec_t v(input logic r, en, stp, input logic [7:0] hr, mn, sc, ah, am,
                             input int er, eb);
    vec_t x;
    x.r = r; x.en = en; x.stp = stp; x.sz = 1'b0; x.tk = 1'b0;
    x.hr = hr; x.mn = mn; x.sc = sc; x.ah = ah; x.am = am;
    x.er = er; x.es = 0; x.eb = eb; x.ec = 0;
    return x;
  endfunction

  vec_t vecs[18];

  initial begin
    int seen, s_min, s_sec;
    rst = 1'b1; sec_tick = 1'b0; alarm_en = 1'b0; stop = 1'b0; snooze = 1'b0;
    hour = 8'h00; min = 8'h00; sec = 8'h00; ahour = 8'h00; amin = 8'h00;

    vecs[0]  = v(1, 1, 0, 8'h07, 8'h29, 8'h59, 8'h07, 8'h30, 0, 0);
    vecs[1]  = v(0, 1, 0, 8'h07, 8'h29, 8'h59, 8'h07, 8'h30, 0, 0);
    vecs[2]  = v(0, 1, 0, 8'h07, 8'h30, 8'h00, 8'h07, 8'h30, 1, 0);
    for (int i = 3; i <= 10; i++)
      vecs[i] = v(0, 1, 0, 8'h07, 8'h30, 8'h01, 8'h07, 8'h30, 1, (i >= 6 && i <= 9) ? 1 : 0);
    vecs[11] = v(0, 1, 1, 8'h07, 8'h30, 8'h01, 8'h07, 8'h30, 0, 0);
    vecs[12] = v(0, 1, 0, 8'h07, 8'h30, 8'h00, 8'h07, 8'h30, 0, 0);
    vecs[13] = v(0, 1, 0, 8'h07, 8'h31, 8'h00, 8'h07, 8'h30, 0, 0);
    vecs[14] = v(0, 1, 0, 8'h07, 8'h30, 8'h00, 8'h07, 8'h30, 1, 0);
    vecs[15] = v(0, 0, 0, 8'h07, 8'h30, 8'h00, 8'h07, 8'h30, 0, 0);
    vecs[16] = v(0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
    vecs[17] = v(0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);

    for (int i = 0; i < 18; i++) begin
      rst = vecs[i].r; alarm_en = vecs[i].en; stop = vecs[i].stp;
      snooze = vecs[i].sz; sec_tick = vecs[i].tk;
      hour = vecs[i].hr; min = vecs[i].mn; sec = vecs[i].sc;
      ahour = vecs[i].ah; amin = vecs[i].am;
      cyc();
      chk($sformatf("vec%0d_ringing", i),  int'(ringing),    vecs[i].er);
      chk($sformatf("vec%0d_snoozing", i), int'(snoozing),   vecs[i].es);
      chk($sformatf("vec%0d_buzzer", i),   int'(buzzer),     vecs[i].eb);
      chk($sformatf("vec%0d_cnt", i),      int'(snooze_cnt), vecs[i].ec);
    end

    // Ring timeout: gate on in seconds 1 and 3, done on the third tick.
    do_reset();
    trigger();
    for (int s = 1; s <= 3; s++) begin
      seen = 0;
      for (int c = 0; c < 10; c++) begin
        cyc();
        if (buzzer) seen = 1;
      end
      chk($sformatf("timeout_buz_sec%0d", s), seen, (s == 2) ? 0 : 1);
      sec_tick = 1'b1; cyc(); sec_tick = 1'b0;
      chk($sformatf("timeout_ring_tick%0d", s), int'(ringing), (s == 3) ? 0 : 1);
    end

    // Three snooze periods, then a fourth edge that must be ignored.
    do_reset();
    trigger();
    for (int i = 1; i <= 3; i++) begin
      snooze = 1'b1; cyc(); snooze = 1'b0;
      chk("snz_enter", int'(snoozing), 1);
      chk("snz_cnt", int'(snooze_cnt), i);
      tick_n(SNZ - 1);
      chk("snz_still", int'(snoozing), 1);
      tick_n(1);
      chk("snz_rering", int'(ringing), 1);
    end
    snooze = 1'b1; cyc(); snooze = 1'b0;
    chk("snz4_ring", int'(ringing), 1);
    chk("snz4_snoozing", int'(snoozing), 0);
    chk("snz4_cnt", int'(snooze_cnt), 3);

    // Snooze edge with sec_tick, then alarm_en drop, then reset mid-ring.
    do_reset();
    trigger();
    snooze = 1'b1; sec_tick = 1'b1; cyc(); snooze = 1'b0; sec_tick = 1'b0;
    chk("cotick_snz", int'(snoozing), 1);
    tick_n(SNZ - 1);
    chk("cotick_full_period", int'(snoozing), 1);
    tick_n(1);
    chk("cotick_rering", int'(ringing), 1);
    snooze = 1'b1; cyc(); snooze = 1'b0;
    chk("en_pre_cnt", int'(snooze_cnt), 2);
    alarm_en = 1'b0; cyc();
    chk("en_off_snoozing", int'(snoozing), 0);
    chk("en_off_cnt", int'(snooze_cnt), 0);
    trigger();
    repeat (5) cyc();
    chk("rst_pre_buz", int'(buzzer), 1);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rst_ringing", int'(ringing), 0);
    chk("rst_buzzer", int'(buzzer), 0);

    // Randomized run around the alarm minute.
    s_min = 29; s_sec = 50; ahour = 8'h07; amin = 8'h30;
    for (int n = 0; n < 6000; n++) begin
      rst      = ($urandom_range(0, 399) == 0);
      alarm_en = ($urandom_range(0, 149) != 0);
      stop     = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 4) == 0) snooze = ~snooze;
      sec_tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) begin
        case ($urandom_range(0, 3))
          0: begin ahour = 8'h00; amin = 8'h00; end
          1: begin ahour = 8'h07; amin = 8'h31; end
          default: begin ahour = 8'h07; amin = 8'h30; end
        endcase
      end
      hour = 8'h07; min = bcd(s_min); sec = bcd(s_sec);
      cyc();
      if (sec_tick) begin
        s_sec++;
        if (s_sec == 60) begin s_sec = 0; s_min++; end
        if (s_min == 31 && s_sec == 20) begin s_min = 29; s_sec = 50; end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
